sprite_line_sched: RTL and testbench
====================================

Name: sprite_line_sched

Overview:
- Per-scanline sprite scheduler for the spritetest video path.
- On each line_start pulse (issued during hblank) it scans a register-based sprite table for the next line. It selects up to MAX_SLOTS vertically-hit sprites and fetches their bitmap rows from one shared synchronous sprite ROM.
- Results are loaded into a shadow slot bank, which becomes the active bank read by the pixel renderers at the next line_start.
- Sits between the video sync counters, the game/keys logic (table writer) and the sprite ROM.

Parameters:
- NUM_SPR, 8: sprite table entries.
- MAX_SLOTS, 4: sprites renderable per line.
- SPR_H, 16: sprite height in rows; must be a power of two.
- SPR_W, 8: sprite width; bits per ROM word.
- CODE_W, 2: sprite picture code width.
- POS_W, 9: width of x, y and vpos.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- line_start, in, 1: one-cycle pulse; swap banks and start a scan.
- vpos, in, POS_W: line to schedule; sampled on line_start.
- tbl_we, in, 1: table write strobe.
- tbl_idx, in, $clog2(NUM_SPR): entry index.
- tbl_x, in, POS_W: entry x.
- tbl_y, in, POS_W: entry y.
- tbl_code, in, CODE_W: entry picture code.
- rom_en, out, 1: ROM read enable.
- rom_addr, out, CODE_W+$clog2(SPR_H): {code,row}.
- rom_data, in, SPR_W: ROM word; valid the cycle after rom_en.
- act_valid, out, MAX_SLOTS: active-bank slot valid bits.
- act_x, out, MAX_SLOTS*POS_W: active-bank slot x positions; slot i at [i*POS_W +: POS_W].
- act_bits, out, MAX_SLOTS*SPR_W: active-bank slot row bitmaps.
- act_ovf, out, 1: the active line had more hits than MAX_SLOTS.
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse when a scan completes.
- late, out, 1: sticky; a line_start arrived while busy.

Behaviour:
- Reset:
  - All outputs 0, both banks cleared, table entries cleared (x=0, y=0, code=0), FSM to IDLE.
  - late cleared only by reset.
- States: IDLE, CHECK, FETCH, CAPTURE, DONE.
- line_start, from any state:
  - shadow bank (valid, x, bits, ovf) copies to the active bank.
  - shadow bank clears; vpos latches; entry index resets to 0.
  - FSM goes to CHECK next cycle.
  - If the FSM was not IDLE/DONE when line_start arrived, set late. The partially filled shadow is still swapped in and the old scan is abandoned, with no further rom_en.
- CHECK (1 cycle per entry):
  - row = (vpos - y) mod 2^POS_W; hit = row < SPR_H.
  - hit and free slot: latch row[$clog2(SPR_H)-1:0] and code → FETCH.
  - hit and all slots used: set shadow ovf; advance.
  - miss: advance.
  - Advance = next entry; after entry NUM_SPR-1 → DONE.
- FETCH (1 cycle): rom_en=1, rom_addr={code,row}. rom_en is 0 in every other state.
- CAPTURE (1 cycle):
  - rom_data → shadow slot[n].bits; entry x → slot[n].x; slot[n].valid=1; n++.
  - Advance as in CHECK.
- Slot order: slots fill in ascending entry index; lower index = slot 0.
- DONE: done=1 for one cycle → IDLE.
- busy = 1 in CHECK/FETCH/CAPTURE.
- Scan length: NUM_SPR + 2*hits_fetched cycles, plus 1 cycle for DONE. Worst case with defaults: 8 + 8 + 1 = 17 cycles after line_start.
- Table writes:
  - Take effect on the next clock edge.
  - A CHECK of the same entry in the same cycle uses the old value.
  - CAPTURE uses the x latched at CHECK.
- Wrap-around:
  - y near 2^POS_W with small vpos still hits, via modulo subtraction; e.g. y=511, vpos=3 → row 4 hit.
  - vpos=y-1 (mod 2^POS_W) → row=2^POS_W-1, miss.
- Simultaneous line_start and reset: reset wins.

Optional Feature:
- Macro SCHED_STATS_EN.
- When defined: adds output ovf_cnt[15:0]. It increments, saturating at 16'hFFFF, on each line_start where the bank being swapped in has ovf=1. Cleared by reset.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset hold 7 cycles, then idle → all outputs 0, rom_en never asserted.
- Entry 2 = (x=40, y=100, code=1); line_start with vpos=105 → one rom_en with rom_addr=0x15. done pulses 11 cycles after line_start. A second line_start gives act_valid=4'b0001, act_x slot0=40, act_bits=rom word 0x15.
- Entries 0..5 all at y=10, x=8*i; vpos=10 → 4 fetches in slots 0..3 with x=0,8,16,24; act_ovf=1 after swap. With SCHED_STATS_EN: ovf_cnt=1.
- Entry 0 y=511, vpos=3 → hit, rom_addr row=4. Entry 1 y=4, vpos=3 → miss.
- Second line_start issued 5 cycles after the first while busy → late=1, rom_en stops, partial shadow swapped in, new scan starts next cycle.
- tbl_we to entry 3 in the same cycle as its CHECK → old y/x used this line; new values used on the following line.

Source files
------------

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans the sprite table for the next line, fetches hit rows from the
// shared sprite ROM into a shadow slot bank, and swaps it into the active bank on line_start. Option: SCHED_STATS_EN.
module sprite_line_sched #(
    parameter int NUM_SPR   = 8,
    parameter int MAX_SLOTS = 4,
    parameter int SPR_H     = 16,
    parameter int SPR_W     = 8,
    parameter int CODE_W    = 2,
    parameter int POS_W     = 9
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               line_start,
    input  logic [POS_W-1:0]                   vpos,
    input  logic                               tbl_we,
    input  logic [$clog2(NUM_SPR)-1:0]         tbl_idx,
    input  logic [POS_W-1:0]                   tbl_x,
    input  logic [POS_W-1:0]                   tbl_y,
    input  logic [CODE_W-1:0]                  tbl_code,
    output logic                               rom_en,
    output logic [CODE_W+$clog2(SPR_H)-1:0]    rom_addr,
    input  logic [SPR_W-1:0]                   rom_data,
    output logic [MAX_SLOTS-1:0]               act_valid,
    output logic [MAX_SLOTS*POS_W-1:0]         act_x,
    output logic [MAX_SLOTS*SPR_W-1:0]         act_bits,
    output logic                               act_ovf,
    output logic                               busy,
    output logic                               done,
    output logic                               late
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]                        ovf_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SPR);
    localparam int ROW_W = $clog2(SPR_H);
    localparam int CNT_W = $clog2(MAX_SLOTS + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_CAPTURE, S_DONE} state_t;

    state_t state_q, state_d;

    logic [POS_W-1:0]  tbl_x_q    [NUM_SPR];
    logic [POS_W-1:0]  tbl_y_q    [NUM_SPR];
    logic [CODE_W-1:0] tbl_code_q [NUM_SPR];

    logic [POS_W-1:0]           vpos_q;
    logic [IDX_W-1:0]           idx_q;
    logic [CNT_W-1:0]           n_q;
    logic [ROW_W-1:0]           row_q;
    logic [CODE_W-1:0]          code_q;
    logic [POS_W-1:0]           xl_q;
    logic [MAX_SLOTS-1:0]       sh_valid;
    logic [MAX_SLOTS*POS_W-1:0] sh_x;
    logic [MAX_SLOTS*SPR_W-1:0] sh_bits;
    logic                       sh_ovf;

    logic [POS_W-1:0] row;
    logic             hit;
    logic             slot_free;
    logic             last;

    // Modulo subtraction lets sprites straddling the top of the frame still hit.
    assign row       = vpos_q - tbl_y_q[idx_q];
    assign hit       = (row[POS_W-1:ROW_W] == '0);
    assign slot_free = (n_q < CNT_W'(MAX_SLOTS));
    assign last      = (idx_q == IDX_W'(NUM_SPR - 1));

    assign rom_en   = (state_q == S_FETCH);
    assign rom_addr = rom_en ? {code_q, row_q} : '0;
    assign busy     = (state_q == S_CHECK) || (state_q == S_FETCH) || (state_q == S_CAPTURE);
    assign done     = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_CHECK: begin
                if (hit && slot_free) state_d = S_FETCH;
                else if (last)        state_d = S_DONE;
                else                  state_d = S_CHECK;
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = last ? S_DONE : S_CHECK;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // A new line always restarts the scan, abandoning any scan still running.
        if (line_start) state_d = S_CHECK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                tbl_x_q[i]    <= '0;
                tbl_y_q[i]    <= '0;
                tbl_code_q[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_x_q[tbl_idx]    <= tbl_x;
            tbl_y_q[tbl_idx]    <= tbl_y;
            tbl_code_q[tbl_idx] <= tbl_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vpos_q    <= '0;
            idx_q     <= '0;
            n_q       <= '0;
            row_q     <= '0;
            code_q    <= '0;
            xl_q      <= '0;
            sh_valid  <= '0;
            sh_x      <= '0;
            sh_bits   <= '0;
            sh_ovf    <= 1'b0;
            act_valid <= '0;
            act_x     <= '0;
            act_bits  <= '0;
            act_ovf   <= 1'b0;
            late      <= 1'b0;
`ifdef SCHED_STATS_EN
            ovf_cnt   <= '0;
`endif
        end else if (line_start) begin
            act_valid <= sh_valid;
            act_x     <= sh_x;
            act_bits  <= sh_bits;
            act_ovf   <= sh_ovf;
            sh_valid  <= '0;
            sh_x      <= '0;
            sh_bits   <= '0;
            sh_ovf    <= 1'b0;
            vpos_q    <= vpos;
            idx_q     <= '0;
            n_q       <= '0;
            if (busy) late <= 1'b1;
`ifdef SCHED_STATS_EN
            if (sh_ovf && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
`endif
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (hit && slot_free) begin
                        row_q  <= row[ROW_W-1:0];
                        code_q <= tbl_code_q[idx_q];
                        xl_q   <= tbl_x_q[idx_q];
                    end else begin
                        if (hit)   sh_ovf <= 1'b1;
                        if (!last) idx_q  <= idx_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int s = 0; s < MAX_SLOTS; s++) begin
                        if (n_q == CNT_W'(s)) begin
                            sh_valid[s]               <= 1'b1;
                            sh_x[s*POS_W +: POS_W]    <= xl_q;
                            sh_bits[s*SPR_W +: SPR_W] <= rom_data;
                        end
                    end
                    n_q <= n_q + 1'b1;
                    if (!last) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched with a synchronous ROM model whose word is {2'b10, addr}.
// Covers reset, single hit, overflow, wrap-around, late line_start, same-cycle table write, reset priority.
module tb_sprite_line_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic [8:0] vpos;
    logic       tbl_we;
    logic [2:0] tbl_idx;
    logic [8:0] tbl_x;
    logic [8:0] tbl_y;
    logic [1:0] tbl_code;
    logic       rom_en;
    logic [5:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] act_valid;
    logic [35:0] act_x;
    logic [31:0] act_bits;
    logic       act_ovf;
    logic       busy;
    logic       done;
    logic       late;
`ifdef SCHED_STATS_EN
    logic [15:0] ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic [5:0] rom_log [$];

    sprite_line_sched dut (
        .clk(clk), .reset(reset), .line_start(line_start), .vpos(vpos),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_code(tbl_code),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .act_valid(act_valid), .act_x(act_x), .act_bits(act_bits), .act_ovf(act_ovf),
        .busy(busy), .done(done), .late(late)
`ifdef SCHED_STATS_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en === 1'b1) begin
            rom_data <= {2'b10, rom_addr};
            rom_log.push_back(rom_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input int x, input int y, input int code);
        tbl_we   = 1'b1;
        tbl_idx  = 3'(idx);
        tbl_x    = 9'(x);
        tbl_y    = 9'(y);
        tbl_code = 2'(code);
        tick;
        tbl_we   = 1'b0;
    endtask

    task automatic ls(input int v);
        line_start = 1'b1;
        vpos       = 9'(v);
        tick;
        line_start = 1'b0;
    endtask

    // lat counts cycles with the line_start cycle numbered 1.
    task automatic wait_done(input int start, output int l);
        l = start;
        while (done !== 1'b1 && l < 60) begin
            tick;
            l++;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rom_en"},    64'(rom_en), 64'h0);
        check({tag, "_busy"},      64'(busy), 64'h0);
        check({tag, "_done"},      64'(done), 64'h0);
        check({tag, "_late"},      64'(late), 64'h0);
        check({tag, "_act_valid"}, 64'(act_valid), 64'h0);
        check({tag, "_act_x"},     64'(act_x), 64'h0);
        check({tag, "_act_bits"},  64'(act_bits), 64'h0);
        check({tag, "_act_ovf"},   64'(act_ovf), 64'h0);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; vpos = '0;
        tbl_we = 1'b0; tbl_idx = '0; tbl_x = '0; tbl_y = '0; tbl_code = '0;

        // reset hold, then idle
        repeat (7) tick;
        check_idle_zero("rst");
        reset = 1'b0;
        repeat (5) tick;
        check_idle_zero("idle");
        check("idle_rom_cnt", 64'(rom_log.size()), 64'd0);
`ifdef SCHED_STATS_EN
        check("idle_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif

        // single hit: entry 2 (x=40,y=100,code=1), vpos=105 -> row 5, addr 0x15
        wr(2, 40, 100, 1);
        rom_log.delete();
        ls(105);
        check("t2_busy", 64'(busy), 64'h1);
        wait_done(1, lat);
        check("t2_done_lat", 64'(lat), 64'd11);
        check("t2_rom_cnt", 64'(rom_log.size()), 64'd1);
        check("t2_rom_addr", 64'(rom_log[0]), 64'h15);
        tick;
        check("t2_done_pulse", 64'(done), 64'h0);
        check("t2_busy_after", 64'(busy), 64'h0);
        ls(105);
        check("t2_act_valid", 64'(act_valid), 64'h1);
        check("t2_act_x0", 64'(act_x[8:0]), 64'd40);
        check("t2_act_bits0", 64'(act_bits[7:0]), 64'h95);
        check("t2_act_ovf", 64'(act_ovf), 64'h0);
        wait_done(1, lat);
        check("t2b_done_lat", 64'(lat), 64'd11);

        // overflow: entries 0..5 at y=10, x=8*i, code=i%4; entries 6,7 at y=0 also hit
        for (int i = 0; i < 6; i++) wr(i, 8 * i, 10, i % 4);
        rom_log.delete();
        ls(10);
        wait_done(1, lat);
        check("t3_done_lat", 64'(lat), 64'd17);
        check("t3_rom_cnt", 64'(rom_log.size()), 64'd4);
        check("t3_rom_a0", 64'(rom_log[0]), 64'h00);
        check("t3_rom_a1", 64'(rom_log[1]), 64'h10);
        check("t3_rom_a2", 64'(rom_log[2]), 64'h20);
        check("t3_rom_a3", 64'(rom_log[3]), 64'h30);
        ls(300);
        check("t3_act_valid", 64'(act_valid), 64'hF);
        check("t3_x0", 64'(act_x[8:0]), 64'd0);
        check("t3_x1", 64'(act_x[17:9]), 64'd8);
        check("t3_x2", 64'(act_x[26:18]), 64'd16);
        check("t3_x3", 64'(act_x[35:27]), 64'd24);
        check("t3_bits", 64'(act_bits), 64'hB0A09080);
        check("t3_act_ovf", 64'(act_ovf), 64'h1);
        check("t3_late", 64'(late), 64'h0);
`ifdef SCHED_STATS_EN
        check("t3_ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
        wait_done(1, lat);
        check("t3b_done_lat", 64'(lat), 64'd9);

        // wrap-around: entry 0 y=511 (vpos 3 -> row 4 hit), entry 1 y=4 (row 511 miss)
        wr(0, 5, 511, 2);
        wr(1, 6, 4, 3);
        for (int i = 2; i < 8; i++) wr(i, 0, 200, 0);
        rom_log.delete();
        ls(3);
        wait_done(1, lat);
        check("t4_done_lat", 64'(lat), 64'd11);
        check("t4_rom_cnt", 64'(rom_log.size()), 64'd1);
        check("t4_rom_addr", 64'(rom_log[0]), 64'h24);
        ls(300);
        check("t4_act_valid", 64'(act_valid), 64'h1);
        check("t4_x0", 64'(act_x[8:0]), 64'd5);
        check("t4_bits0", 64'(act_bits[7:0]), 64'hA4);
        check("t4_act_ovf", 64'(act_ovf), 64'h0);
`ifdef SCHED_STATS_EN
        check("t4_ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
        wait_done(1, lat);

        // late: entries 0 and 1 hit at vpos 3; second line_start 5 cycles later, during entry 1's fetch
        wr(1, 7, 0, 1);
        rom_log.delete();
        ls(3);
        repeat (4) tick;
        check("t5_rom_en_pre", 64'(rom_en), 64'h1);
        check("t5_late_pre", 64'(late), 64'h0);
        ls(300);
        check("t5_late", 64'(late), 64'h1);
        check("t5_rom_en", 64'(rom_en), 64'h0);
        check("t5_busy", 64'(busy), 64'h1);
        check("t5_act_valid", 64'(act_valid), 64'h1);
        check("t5_x0", 64'(act_x[8:0]), 64'd5);
        check("t5_bits0", 64'(act_bits[7:0]), 64'hA4);
        wait_done(1, lat);
        check("t5_done_lat", 64'(lat), 64'd9);
        check("t5_rom_cnt", 64'(rom_log.size()), 64'd2);
        check("t5_rom_a1", 64'(rom_log[1]), 64'h13);
        check("t5_late_sticky", 64'(late), 64'h1);

        // same-cycle write during entry 3's CHECK: old (y=50,x=33,code=2) this line, new after
        wr(0, 0, 200, 0);
        wr(1, 0, 200, 0);
        wr(3, 33, 50, 2);
        rom_log.delete();
        ls(52);
        repeat (3) tick;
        wr(3, 99, 52, 1);
        wait_done(5, lat);
        check("t6_done_lat", 64'(lat), 64'd11);
        check("t6_rom_cnt", 64'(rom_log.size()), 64'd1);
        check("t6_rom_addr_old", 64'(rom_log[0]), 64'h22);
        rom_log.delete();
        ls(52);
        check("t6_act_valid", 64'(act_valid), 64'h1);
        check("t6_x0_old", 64'(act_x[8:0]), 64'd33);
        check("t6_bits0_old", 64'(act_bits[7:0]), 64'hA2);
        wait_done(1, lat);
        check("t6_rom_addr_new", 64'(rom_log[0]), 64'h10);
        ls(300);
        check("t6_x0_new", 64'(act_x[8:0]), 64'd99);
        check("t6_bits0_new", 64'(act_bits[7:0]), 64'h90);

        // reset wins over a simultaneous line_start
        reset = 1'b1;
        ls(52);
        check_idle_zero("rst_ls");
`ifdef SCHED_STATS_EN
        check("rst_ls_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
        reset = 1'b0;
        tick;
        check("rst_ls_busy_after", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
